// File: rtl/aes_128_pkg.sv
// Shared types, round constants and column/row helpers for the AES-128 core.
// Optional last-round-key output is enabled by AES_128_LAST_KEY_EN.
package aes_128_pkg;

    localparam int NR = 10;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } fsm_t;

    // Indexed directly by the round counter; slot 0 and 11..15 unused.
    localparam byte_t RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04,
        8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t mix_column(input word_t col);
        byte_t a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    endfunction

    // Byte n sits at bits [127-8n -: 8]; row r, column c is byte r+4c.
    function automatic block_t shift_rows(input block_t s);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] =
                    s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_128_sbox.sv
// Combinational AES S-box: GF(2^8) inverse followed by the affine map.
// Zero has no inverse and maps to zero, giving S(00)=63.
module aes_128_sbox
    import aes_128_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    byte_t w_inv;

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 = a^-1 for a != 0, built from repeated squaring.
    function automatic byte_t gf_inv(input byte_t a);
        byte_t p;
        byte_t r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    assign w_inv = gf_inv(i_byte);

    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_128_core.sv
// Iterative AES-128 encryptor: one round per clock, keys expanded on the fly.
// Define AES_128_LAST_KEY_EN to expose round key 10 on last_key.
module aes_128_core
    import aes_128_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] out
`ifdef AES_128_LAST_KEY_EN
    ,
    output logic [127:0] last_key
`endif
);

    fsm_t   r_fsm;
    fsm_t   w_fsm_nxt;
    block_t r_data;
    block_t r_key;
    block_t r_out;
    logic   [3:0] r_cnt;
    logic   r_done;

    logic   w_load;
    logic   w_step;
    logic   w_fin;
    logic   w_last;

    word_t  w_rot;
    word_t  w_sub;
    word_t  w_tmp;
    word_t  w_k0;
    word_t  w_k1;
    word_t  w_k2;
    word_t  w_k3;
    block_t w_nk;

    block_t w_sb;
    block_t w_sr;
    block_t w_mc;
    block_t w_round;

    assign w_last = (r_cnt == 4'(NR));

    // Key schedule: next round key from the current one.
    assign w_rot = {r_key[23:0], r_key[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_ks
        aes_128_sbox u_sbox (
            .i_byte (w_rot[31-8*i -: 8]),
            .o_byte (w_sub[31-8*i -: 8])
        );
    end

    assign w_tmp = w_sub ^ {RCON[r_cnt], 24'h000000};
    assign w_k0  = r_key[127:96] ^ w_tmp;
    assign w_k1  = r_key[95:64]  ^ w_k0;
    assign w_k2  = r_key[63:32]  ^ w_k1;
    assign w_k3  = r_key[31:0]   ^ w_k2;
    assign w_nk  = {w_k0, w_k1, w_k2, w_k3};

    // Round datapath: SubBytes, ShiftRows, MixColumns, AddRoundKey.
    for (genvar i = 0; i < 16; i++) begin : g_sb
        aes_128_sbox u_sbox (
            .i_byte (r_data[127-8*i -: 8]),
            .o_byte (w_sb[127-8*i -: 8])
        );
    end

    assign w_sr = shift_rows(w_sb);

    for (genvar c = 0; c < 4; c++) begin : g_mc
        assign w_mc[127-32*c -: 32] =
            mix_column(w_sr[127-32*c -: 32]);
    end

    assign w_round = (w_last ? w_sr : w_mc) ^ w_nk;

    // Next-state and control strobes for the round sequencer.
    always_comb begin
        w_fsm_nxt = r_fsm;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_fin     = 1'b0;
        unique case (r_fsm)
            S_IDLE: begin
                if (start) begin
                    w_load    = 1'b1;
                    w_fsm_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_fin     = 1'b1;
                    w_fsm_nxt = S_IDLE;
                end
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // State, round data, key and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm  <= S_IDLE;
            r_data <= '0;
            r_key  <= '0;
            r_out  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_fsm  <= w_fsm_nxt;
            r_done <= w_fin;
            if (w_load) begin
                r_data <= state ^ key;
                r_key  <= key;
                r_cnt  <= 4'd1;
            end else if (w_step) begin
                r_data <= w_round;
                r_key  <= w_nk;
                r_cnt  <= w_last ? 4'd0 : r_cnt + 4'd1;
                if (w_fin) r_out <= w_round;
            end
        end
    end

`ifdef AES_128_LAST_KEY_EN
    logic [127:0] r_last_key;

    // Final round key, captured with the ciphertext.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_key <= '0;
        end else if (w_fin) begin
            r_last_key <= w_nk;
        end
    end

    assign last_key = r_last_key;
`endif

    assign busy = (r_fsm == S_RUN);
    assign done = r_done;
    assign out  = r_out;

endmodule

// File: tb/tb_aes_128_core.sv
// Directed-vector bench for aes_128_core (FIPS-197 App. B / C.1, zero key).
// Define AES_128_LAST_KEY_EN to also check last_key.
module tb_aes_128_core;

    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_LK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] Z_LK  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] state_i;
    logic [127:0] key_i;
    logic         busy;
    logic         done;
    logic [127:0] out_w;
`ifdef AES_128_LAST_KEY_EN
    logic [127:0] last_key;
`endif

    int n_vec = 0;
    int n_err = 0;

    aes_128_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .state    (state_i),
        .key      (key_i),
        .busy     (busy),
        .done     (done),
        .out      (out_w)
`ifdef AES_128_LAST_KEY_EN
        ,
        .last_key (last_key)
`endif
    );

    always #5 clk = ~clk;

    // Pulse start for one accepting edge; returns #1 after that edge.
    task automatic launch(input logic [127:0] s, input logic [127:0] k);
        @(negedge clk);
        state_i = s;
        key_i   = k;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count rising edges until done is seen (-1 if the budget expires).
    task automatic wait_done(input int lim, output int lat);
        lat = -1;
        for (int i = 1; i <= lim; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n   = 1'b1;
        start   = 1'b0;
        state_i = '0;
        key_i   = '0;
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_w !== 128'h0) begin
            n_err++;
            $display("FAIL reset_out: got %h expected %h", out_w, 128'h0);
        end
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got busy=%b done=%b expected 0 0",
                     busy, done);
        end
`ifdef AES_128_LAST_KEY_EN
        n_vec++;
        if (last_key !== 128'h0) begin
            n_err++;
            $display("FAIL reset_last_key: got %h expected 0", last_key);
        end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fips_b;
        int lat;
        launch(B_PT, B_KEY);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b_busy: got %b expected 1", busy);
        end
        wait_done(20, lat);
        n_vec++;
        if (lat != 10) begin
            n_err++;
            $display("FAIL b_latency: got %0d expected 10", lat);
        end
        n_vec++;
        if (out_w !== B_CT) begin
            n_err++;
            $display("FAIL b_out: got %h expected %h", out_w, B_CT);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b_busy_done: got %b expected 0", busy);
        end
`ifdef AES_128_LAST_KEY_EN
        n_vec++;
        if (last_key !== B_LK) begin
            n_err++;
            $display("FAIL b_last_key: got %h expected %h", last_key, B_LK);
        end
`endif
        @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b0 || out_w !== B_CT) begin
            n_err++;
            $display("FAIL b_pulse: got done=%b out=%h expected 0 %h",
                     done, out_w, B_CT);
        end
    endtask

    task automatic test_fips_c1;
        int lat;
        launch(C_PT, C_KEY);
        wait_done(20, lat);
        n_vec++;
        if (lat != 10) begin
            n_err++;
            $display("FAIL c1_latency: got %0d expected 10", lat);
        end
        n_vec++;
        if (out_w !== C_CT) begin
            n_err++;
            $display("FAIL c1_out: got %h expected %h", out_w, C_CT);
        end
    endtask

    task automatic test_zero;
        int lat;
        launch(128'h0, 128'h0);
        wait_done(20, lat);
        n_vec++;
        if (lat != 10 || out_w !== Z_CT) begin
            n_err++;
            $display("FAIL zero_out: got lat=%0d %h expected 10 %h",
                     lat, out_w, Z_CT);
        end
`ifdef AES_128_LAST_KEY_EN
        n_vec++;
        if (last_key !== Z_LK) begin
            n_err++;
            $display("FAIL zero_last_key: got %h expected %h", last_key, Z_LK);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int lat;
        int extra;
        @(negedge clk);
        state_i = B_PT;
        key_i   = B_KEY;
        start   = 1'b1;
        @(posedge clk);
        #1;
        state_i = C_PT;
        key_i   = C_KEY;
        wait_done(20, lat);
        n_vec++;
        if (lat != 10 || out_w !== B_CT) begin
            n_err++;
            $display("FAIL b2b_first: got lat=%0d %h expected 10 %h",
                     lat, out_w, B_CT);
        end
        wait_done(20, lat);
        start = 1'b0;
        n_vec++;
        if (lat != 11) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d expected 11", lat);
        end
        n_vec++;
        if (out_w !== C_CT) begin
            n_err++;
            $display("FAIL b2b_second: got %h expected %h", out_w, C_CT);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL b2b_extra: got %0d busy/done cycles expected 0",
                     extra);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        launch(C_PT, C_KEY);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_w !== 128'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got out=%h busy=%b done=%b expected 0",
                     out_w, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(15, lat);
        n_vec++;
        if (lat != -1) begin
            n_err++;
            $display("FAIL mid_no_done: got done after %0d expected none", lat);
        end
        launch(C_PT, C_KEY);
        wait_done(20, lat);
        n_vec++;
        if (lat != 10 || out_w !== C_CT) begin
            n_err++;
            $display("FAIL mid_rerun: got lat=%0d %h expected 10 %h",
                     lat, out_w, C_CT);
        end
    endtask

    task automatic test_input_change;
        int lat;
        launch(B_PT, B_KEY);
        state_i = 128'h0;
        key_i   = 128'hffffffffffffffffffffffffffffffff;
        wait_done(20, lat);
        n_vec++;
        if (lat != 10 || out_w !== B_CT) begin
            n_err++;
            $display("FAIL input_change: got lat=%0d %h expected 10 %h",
                     lat, out_w, B_CT);
        end
    endtask

    initial begin
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_input_change();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_128_core.md
Name: aes_128_core

Overview:
- Iterative AES-128 encryption engine, FIPS-197, encrypt direction only.
- Executes one round per clock, 11 round keys generated on the fly; no key RAM.
- Sits beneath the crypto top level: the top supplies a 128-bit plaintext and key, pulses start, and captures out when done pulses.

Parameters:
- NR, 10, number of AES rounds (fixed for AES-128; other values unsupported).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin encryption of state/key; sampled only when idle
- state  input  128  plaintext, bit 127 = byte 0 (FIPS byte order, MSB first)
- key  input  128  cipher key, same byte order
- busy  output  1  high while a block is in flight
- done  output  1  one-cycle pulse; out valid in the same cycle
- out  output  128  ciphertext register, same byte order

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, async): out=0, done=0, busy=0, round counter=0, internal state/round-key registers=0.
- Accept: rising edge with start=1 and busy=0, called edge N.
  - Load data register with state XOR key (round 0 AddRoundKey).
  - Load key register with key.
  - Set busy=1 and counter=1.
- Edges N+1..N+9: full round (SubBytes, ShiftRows, MixColumns, AddRoundKey) with the next round key.
  - Next key computed combinationally from the key register (RotWord, SubWord, Rcon[counter]) and registered alongside data.
  - Counter increments each round.
- Edge N+10: final round without MixColumns.
  - Result written to out.
  - done=1 for exactly one cycle, busy=0.
- Latency: 10 cycles from accepting edge to done. Throughput: one block per 11 cycles, since a new start is accepted on the cycle done is high.
- out holds its value until the next block completes. It never shows intermediate states.
- start while busy=1 is ignored. state/key may change freely after acceptance.
- Reset asserted mid-operation aborts the block; no done is produced.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- S-box: standard FIPS table, either ROM or GF(2^8) inverse + affine. Must match the table bit-exactly, including S(00)=63.
- GF multiply by 2 (xtime): shift left, XOR 0x1b on carry.

Optional Feature:
- Macro AES_128_LAST_KEY_EN.
- Defined: extra output last_key[127:0], reset 0, updated with round key 10 at edge N+10 together with out. Used to seed a decryptor.
- Undefined: port and its register are absent. All other behaviour is identical.

Decomposition:
- Package aes_128_pkg:
  - NR constant and the Rcon array
  - typedefs for byte, word (32b), block (128b)
  - functions xtime, mix_column, shift_rows
- One sub-module, aes_128_sbox: combinational 8-bit byte substitution.
  - 16 instances for data SubBytes, 4 for key SubWord.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, state 3243f6a8885a308d313198a2e0370734, start pulse -> done exactly 10 cycles later, out=3925841d02dc09fbdc118597196a0b32 (last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 when enabled).
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, state 00112233445566778899aabbccddeeff -> out=69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero key and state -> out=66e94bd4ef8a2c3b884cfa59ca342b2e (last_key=b4ef5bcb3e92e21123e951cf6f8f188e).
- Back-to-back: App. B block, then App. C.1 block with start raised on the done cycle -> second done 11 cycles after the first, both ciphertexts correct; start held high while busy causes no extra acceptance.
- Reset mid-block: drop rst_n at cycle 5 after start -> out=0, busy=0, done=0 immediately; no done follows; a later App. C.1 run still gives 69c4e0d86a7b0430d8cdb78070b4c55a.
- Input change after acceptance: change state/key one cycle after start -> result still matches the originally accepted App. B vector.
